// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: single-outstanding request/grant/response memory port
// feeding an in-order fetch queue toward decode, with redirect flush of stale fetches.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pcplus4,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FLUSH} state_t;

    localparam int PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FQ_DEPTH);

    state_t             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        req_pc_q, req_pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]        head_instr_q, head_instr_d;
    logic [31:0]        head_pc_q, head_pc_d;
    logic [31:0]        head_p4_q;
    logic [31:0]        instr_mem_q [FQ_DEPTH];
    logic [31:0]        pc_mem_q    [FQ_DEPTH];
    logic               push, pop, head_new;
    logic               unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        push       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!redirect_valid && (cnt_q < DEPTH_C)) state_d = S_REQ;
            end
            S_REQ: begin
                if (imem_gnt) begin
                    // A grant coinciding with a redirect leaves a stale response to drain
                    state_d    = redirect_valid ? S_FLUSH : S_WAIT;
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = S_IDLE;
                    push    = !redirect_valid;
                end else if (redirect_valid) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (imem_rvalid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (redirect_valid) fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end

    assign pop = if_valid && if_ready && !redirect_valid;

    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        if (redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end
        // The new head is the entry being written this cycle when the read pointer lands on it
        head_new     = push && (rd_ptr_d == wr_ptr_q);
        head_instr_d = head_new ? imem_rdata : instr_mem_q[rd_ptr_d];
        head_pc_d    = head_new ? req_pc_q   : pc_mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            fetch_pc_q   <= RESET_PC;
            req_pc_q     <= RESET_PC;
            cnt_q        <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            head_instr_q <= '0;
            head_pc_q    <= '0;
            head_p4_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            cnt_q      <= cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            // Head registers hold their last contents while the queue is empty
            if (cnt_d != '0) begin
                head_instr_q <= head_instr_d;
                head_pc_q    <= head_pc_d;
                head_p4_q    <= head_pc_d + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]    <= req_pc_q;
        end
    end

    assign imem_req   = (state_q == S_REQ);
    assign imem_addr  = fetch_pc_q;
    assign busy       = (state_q != S_IDLE);
    assign if_valid   = (cnt_q != '0);
    assign if_instr   = head_instr_q;
    assign if_pc      = head_pc_q;
    assign if_pcplus4 = head_p4_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer: the bench plays instruction memory and decode,
// and keeps a queue-level model of expected fetch addresses and delivered instructions.
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          FQ_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid, if_ready, busy;
    logic [31:0] if_instr, if_pc, if_pcplus4;

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .if_pc(if_pc), .if_pcplus4(if_pcplus4), .busy(busy)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    int          n_checks = 0;
    int          n_errors = 0;
    entry_t      mq[$];
    logic [31:0] granted[$];
    logic [31:0] exp_pc, last_pc, last_instr, last_p4, pend_addr, rd_tgt;
    bit          pend, pend_stale, wrap_seen;
    int          pend_due, cyc, n_pops;
    int          p_gnt, lat_max, p_ready, p_redir, rd_when;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic model_reset();
        mq.delete();
        granted.delete();
        exp_pc     = RESET_PC;
        last_pc    = '0;
        last_instr = '0;
        last_p4    = '0;
        pend       = 1'b0;
        pend_stale = 1'b0;
    endtask

    task automatic drive_idle();
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b0;
    endtask

    task automatic check_reset_vals();
        check32("rst_imem_req", 32'(imem_req), 32'd0);
        check32("rst_imem_addr", imem_addr, RESET_PC);
        check32("rst_if_valid", 32'(if_valid), 32'd0);
        check32("rst_if_instr", if_instr, 32'd0);
        check32("rst_if_pc", if_pc, 32'd0);
        check32("rst_if_pcplus4", if_pcplus4, 32'd0);
        check32("rst_busy", 32'(busy), 32'd0);
    endtask

    // Asserts reset away from a clock edge, then releases it on a falling edge
    task automatic do_reset();
        #2 rst = 1'b1;
        drive_idle();
        #1 check_reset_vals();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check32("req_at_release", 32'(imem_req), 32'd0);
        @(negedge clk);
        cyc++;
        check32("req_after_release", 32'(imem_req), 32'd1);
        check32("addr_after_release", imem_addr, RESET_PC);
    endtask

    task automatic check_outputs();
        check32("if_valid", 32'(if_valid), 32'(mq.size() != 0));
        check32("if_pc", if_pc, last_pc);
        check32("if_instr", if_instr, last_instr);
        check32("if_pcplus4", if_pcplus4, last_p4);
        check32("imem_addr", imem_addr, exp_pc);
        check32("busy", 32'(busy), 32'(imem_req || pend));
        if (imem_req) check32("req_while_outstanding", 32'(pend), 32'd0);
        if (mq.size() >= FQ_DEPTH) check32("req_when_full", 32'(imem_req), 32'd0);
        if (mq.size() != 0 && mq[0].pc == 32'hFFFF_FFFC) begin
            check32("wrap_pcplus4", if_pcplus4, 32'd0);
            wrap_seen = 1'b1;
        end
    endtask

    // One clock cycle, entered and left on a falling edge
    task automatic step();
        bit          req, gnt, rv, rd, rdy, pop;
        logic [31:0] tgt, req_addr;
        check_outputs();
        req      = imem_req;
        req_addr = exp_pc;
        gnt      = req && ($urandom_range(99) < p_gnt);
        rv       = pend && (cyc >= pend_due);
        rdy      = ($urandom_range(99) < p_ready);
        rd       = ($urandom_range(999) < p_redir);
        tgt      = $urandom;
        case (rd_when)
            1: if (req && gnt) begin rd = 1'b1; tgt = rd_tgt; rd_when = 0; end
            2: if (req && !gnt) begin rd = 1'b1; tgt = rd_tgt; rd_when = 0; end
            3: if (pend && !rv && !pend_stale) begin rd = 1'b1; tgt = rd_tgt; rd_when = 0; end
            default: ;
        endcase
        imem_gnt       = gnt;
        imem_rvalid    = rv;
        imem_rdata     = rv ? mem_word(pend_addr) : $urandom;
        redirect_valid = rd;
        redirect_pc    = tgt;
        if_ready       = rdy;

        pop = (mq.size() != 0) && rdy;
        if (rd) begin
            mq.delete();
            exp_pc = {tgt[31:2], 2'b00};
            if (pend) pend_stale = 1'b1;
        end else begin
            if (pop) begin
                void'(mq.pop_front());
                n_pops++;
            end
            if (rv && !pend_stale) mq.push_back({pend_addr, mem_word(pend_addr)});
            if (gnt) exp_pc = exp_pc + 32'd4;
        end
        if (rv) pend = 1'b0;
        if (gnt) begin
            pend       = 1'b1;
            pend_addr  = req_addr;
            pend_stale = rd;
            pend_due   = cyc + $urandom_range(lat_max, 1);
            granted.push_back(req_addr);
        end
        if (mq.size() != 0) begin
            last_pc    = mq[0].pc;
            last_instr = mq[0].instr;
            last_p4    = mq[0].pc + 32'd4;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_oneshot(input int kind, input logic [31:0] tgt, input int cycles);
        rd_when = kind;
        rd_tgt  = tgt;
        repeat (cycles) step();
        check32("redirect_fired", 32'(rd_when), 32'd0);
        rd_when = 0;
    endtask

    initial begin
        cyc = 0; n_pops = 0; rd_when = 0; wrap_seen = 1'b0;
        p_gnt = 100; lat_max = 1; p_ready = 0; p_redir = 0;
        drive_idle();
        do_reset();

        // Decode stalled: queue fills to depth and fetching stops
        repeat (20) step();
        check32("full_queue_size", 32'(mq.size()), 32'(FQ_DEPTH));
        check32("full_grants", 32'(granted.size()), 32'(FQ_DEPTH));
        check32("grant0", granted[0], 32'h0);
        check32("grant1", granted[1], 32'h4);
        check32("full_no_req", 32'(imem_req), 32'd0);

        // Drain, then steady streaming
        p_ready = 100;
        repeat (30) step();
        check32("grant2", granted[2], 32'h8);
        check32("stream_progress", 32'(n_pops >= 8), 32'd1);

        lat_max = 3;
        run_oneshot(3, 32'h0000_0100, 40);
        lat_max = 1;
        run_oneshot(1, 32'h0000_0203, 40);
        p_gnt = 50;
        run_oneshot(2, 32'h0000_0040, 60);
        p_gnt = 100;
        run_oneshot(1, 32'hFFFF_FFFC, 30);
        check32("wrap_seen", 32'(wrap_seen), 32'd1);

        // Mixed random traffic
        p_gnt = 60; lat_max = 4; p_ready = 70; p_redir = 30;
        repeat (2500) step();
        check32("random_progress", 32'(n_pops > 100), 32'd1);

        // Reset while a live response is outstanding
        p_redir = 0; p_gnt = 100; lat_max = 4; p_ready = 100;
        for (int i = 0; i < 200 && !(pend && !pend_stale); i++) step();
        check32("wait_reached", 32'(pend && !pend_stale), 32'd1);
        do_reset();
        p_gnt = 100; lat_max = 1; p_ready = 100;
        repeat (30) step();
        check32("post_reset_grant0", granted[0], RESET_PC);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
